// File: rtl/calc_sequencer.sv
// Entry/settle/hold controller for the 7-bit four-function calculator datapath.
// Optional CALC_CHAIN_EN: a press in SHOW feeds the answer back in as operand A.
module calc_sequencer #(
  parameter int WIDTH         = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on_off,
  input  logic             enter,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [3:0]       sw_op,
  input  logic [WIDTH-1:0] dp_result,
  output logic             dp_on,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic [3:0]       dp_op,
  output logic [WIDTH-1:0] ans,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       step
);

  typedef enum logic [2:0] {
    OFF, LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW, ERROR
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic             press;
  logic             onehot;
  logic [3:0]       cnt, cnt_n;
  logic [WIDTH-1:0] a_n, b_n, ans_n;
  logic [3:0]       op_n;
  logic [1:0]       step_n;

  // two-flop synchroniser plus one history flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= enter;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press  = s2 & ~s3;
  assign onehot = (sw_op != 4'd0) &&
                  ((sw_op & (sw_op - 4'd1)) == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      dp_a  <= '0;
      dp_b  <= '0;
      dp_op <= '0;
      ans   <= '0;
      dp_on <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      step  <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dp_a  <= a_n;
      dp_b  <= b_n;
      dp_op <= op_n;
      ans   <= ans_n;
      dp_on <= (state_n != OFF);
      busy  <= (state_n == EXEC);
      done  <= (state_n == SHOW);
      err   <= (state_n == ERROR);
      step  <= step_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = dp_a;
    b_n     = dp_b;
    op_n    = dp_op;
    ans_n   = ans;
    if (!on_off) begin
      state_n = OFF;
      cnt_n   = '0;
      a_n     = '0;
      b_n     = '0;
      op_n    = '0;
      ans_n   = '0;
    end else begin
      unique case (state)
        OFF: state_n = LOAD_A;
        LOAD_A:
          if (press) begin
            a_n     = sw_data;
            state_n = LOAD_B;
          end
        LOAD_B:
          if (press) begin
            b_n     = sw_data;
            state_n = LOAD_OP;
          end
        LOAD_OP:
          if (press) begin
            if (!onehot) begin
              ans_n   = '1;
              state_n = ERROR;
            end else if (sw_op == 4'b1000 &&
                         dp_b == '0) begin
              ans_n   = '1;
              state_n = ERROR;
            end else begin
              op_n    = sw_op;
              cnt_n   = '0;
              state_n = EXEC;
            end
          end
        EXEC:
          if (cnt == LAST) begin
            ans_n   = dp_result;
            op_n    = '0;
            cnt_n   = '0;
            state_n = SHOW;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        SHOW:
          if (press) begin
`ifdef CALC_CHAIN_EN
            a_n     = ans;
            state_n = LOAD_B;
`else
            state_n = LOAD_A;
`endif
          end
        ERROR: begin
          ans_n = '1;
          if (press) begin
            ans_n   = '0;
            state_n = LOAD_A;
          end
        end
        default: state_n = OFF;
      endcase
    end
  end

  always_comb begin
    step_n = 2'd3;
    unique case (state_n)
      OFF:     step_n = 2'd0;
      LOAD_A:  step_n = 2'd0;
      LOAD_B:  step_n = 2'd1;
      LOAD_OP: step_n = 2'd2;
      default: step_n = 2'd3;
    endcase
  end

endmodule
